pong_ball: RTL and testbench

//  Ball engine for the two-player pong datapath. Consumes the paddle centre coordinates from the paddle block,

---
 rtl/pong_ball.sv | 233 +++++++++++++++++++++++
 tb/tb_pong_ball.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pong_ball.sv
// pong_ball: ball engine for the two-player pong datapath.
// Moves the ball on a divided tick, bounces it off the walls and paddles,
// detects misses, keeps score and draws the ball for the pixel mux.
// Optional feature macro: PONG_BALL_SPEEDUP_EN (each paddle hit adds 1 px/tick,
// capped at 4, back to 1 on every serve). Without it the speed is fixed at 1.
module pong_ball #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 16,
  parameter int PADDLE_H    = 80,
  parameter int TICK_DIV    = 250000,
  parameter int SERVE_TICKS = 100,
  parameter int WIN_SCORE   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [9:0]  x_paddle1,
  input  logic [9:0]  y_paddle1,
  input  logic [9:0]  x_paddle2,
  input  logic [9:0]  y_paddle2,
  output logic        ball_on,
  output logic [11:0] rgb_ball,
  output logic [9:0]  x_ball,
  output logic [9:0]  y_ball,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        point1,
  output logic        point2,
  output logic        game_over
);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
  localparam logic [9:0]  X_CTR  = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  Y_CTR  = 10'(V_ACTIVE / 2);
  localparam logic [9:0]  Y_TOP  = 10'(BALL_SIZE / 2);
  localparam logic [9:0]  Y_BOT  = 10'(V_ACTIVE - BALL_SIZE / 2);
  localparam logic [9:0]  SNAP   = 10'(PADDLE_W / 2 + BALL_SIZE / 2);
  localparam logic [3:0]  WIN_S  = 4'(WIN_SCORE);
  localparam logic signed [10:0] HALF_S = 11'(BALL_SIZE / 2);
  localparam logic signed [10:0] PW2_S  = 11'(PADDLE_W / 2);
  localparam logic signed [10:0] PH2_S  = 11'(PADDLE_H / 2);
  localparam logic signed [10:0] HACT_S = 11'(H_ACTIVE);
  localparam logic signed [10:0] VACT_S = 11'(V_ACTIVE);
  localparam logic signed [10:0] ZERO_S = 11'sd0;
  localparam logic signed [10:0] ONE_S  = 11'sd1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   srv_cnt_q, srv_cnt_d;
  logic [9:0]      x_ball_q, x_ball_d, y_ball_q, y_ball_d;
  logic            dx_pos_q, dx_pos_d, dy_pos_q, dy_pos_d;
  logic            srv_dy_pos_q, srv_dy_pos_d;
  logic            p1_scored_q, p1_scored_d;
  logic [3:0]      score1_q, score1_d, score2_q, score2_d;
  logic [2:0]      speed;
`ifdef PONG_BALL_SPEEDUP_EN
  logic [2:0]      speed_q, speed_d;
  assign speed = speed_q;
`else
  assign speed = 3'd1;
`endif

  logic            tick;
  logic signed [10:0] sx, sy, nx, ny, spd, xs, ys;
  logic signed [10:0] p1_face, p2_face, p1_top, p1_bot, p2_top, p2_bot;
  logic            ov1, ov2, hit1, hit2, miss_left, miss_right;
  logic [9:0]      hx1, hx2;

  // Geometry of the next move; paddle inputs only matter on the tick edge.
  always_comb begin
    tick       = (cnt_q == TICK_LAST);
    sx         = {1'b0, x_ball_q};
    sy         = {1'b0, y_ball_q};
    xs         = {1'b0, x};
    ys         = {1'b0, y};
    spd        = {8'd0, speed};
    nx         = dx_pos_q ? sx + spd : sx - spd;
    ny         = dy_pos_q ? sy + spd : sy - spd;
    p1_face    = {1'b0, x_paddle1} + PW2_S;
    p2_face    = {1'b0, x_paddle2} - PW2_S;
    p1_top     = {1'b0, y_paddle1} - PH2_S;
    p1_bot     = {1'b0, y_paddle1} + PH2_S;
    p2_top     = {1'b0, y_paddle2} - PH2_S;
    p2_bot     = {1'b0, y_paddle2} + PH2_S;
    ov1        = (sy + HALF_S >= p1_top) && (sy - HALF_S < p1_bot);
    ov2        = (sy + HALF_S >= p2_top) && (sy - HALF_S < p2_bot);
    // The "current edge" term stops a ball that is already past the face from being caught.
    hit1       = !dx_pos_q && (nx - HALF_S <= p1_face)
                 && (sx - HALF_S > p1_face - spd - ONE_S) && ov1;
    hit2       = dx_pos_q && (nx + HALF_S >= p2_face)
                 && (sx + HALF_S < p2_face + spd + ONE_S) && ov2;
    miss_left  = !dx_pos_q && (nx - HALF_S <= ZERO_S);
    miss_right = dx_pos_q && (nx + HALF_S >= HACT_S);
    hx1        = x_paddle1 + SNAP;
    hx2        = x_paddle2 - SNAP;
  end

  // Next-state logic: tick divider, serve/play/point/over sequencing and ball motion.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    srv_cnt_d    = srv_cnt_q;
    x_ball_d     = x_ball_q;
    y_ball_d     = y_ball_q;
    dx_pos_d     = dx_pos_q;
    dy_pos_d     = dy_pos_q;
    srv_dy_pos_d = srv_dy_pos_q;
    p1_scored_d  = p1_scored_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
`ifdef PONG_BALL_SPEEDUP_EN
    speed_d      = speed_q;
`endif
    case (state_q)
      S_SERVE: begin
        if (tick) begin
          if (srv_cnt_q == SERVE_LAST) state_d = S_PLAY;
          else                         srv_cnt_d = srv_cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (tick) begin
          // Walls act on y regardless of what happens in x, so corner hits work.
          if (ny - HALF_S <= ZERO_S) begin
            y_ball_d = Y_TOP;
            dy_pos_d = 1'b1;
          end else if (ny + HALF_S >= VACT_S) begin
            y_ball_d = Y_BOT;
            dy_pos_d = 1'b0;
          end else begin
            y_ball_d = ny[9:0];
          end
          if (hit1 || hit2) begin
            x_ball_d = hit1 ? hx1 : hx2;
            dx_pos_d = hit1;
`ifdef PONG_BALL_SPEEDUP_EN
            if (speed_q < 3'd4) speed_d = speed_q + 3'd1;
`endif
          end else if (miss_left) begin
            state_d     = S_POINT;
            p1_scored_d = 1'b0;
            if (score2_q < WIN_S) score2_d = score2_q + 4'd1;
          end else if (miss_right) begin
            state_d     = S_POINT;
            p1_scored_d = 1'b1;
            if (score1_q < WIN_S) score1_d = score1_q + 4'd1;
          end else begin
            x_ball_d = nx[9:0];
          end
        end
      end
      S_POINT: begin
        x_ball_d = X_CTR;
        y_ball_d = Y_CTR;
        if ((p1_scored_q ? score1_q : score2_q) == WIN_S) begin
          state_d = S_OVER;
        end else begin
          state_d      = S_SERVE;
          srv_cnt_d    = '0;
          dx_pos_d     = p1_scored_q;   // serve toward whoever conceded
          dy_pos_d     = !srv_dy_pos_q;
          srv_dy_pos_d = !srv_dy_pos_q;
`ifdef PONG_BALL_SPEEDUP_EN
          speed_d      = 3'd1;
`endif
        end
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_SERVE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset) begin
      state_q      <= S_SERVE;
      cnt_q        <= '0;
      srv_cnt_q    <= '0;
      x_ball_q     <= X_CTR;
      y_ball_q     <= Y_CTR;
      dx_pos_q     <= 1'b1;
      dy_pos_q     <= 1'b1;
      srv_dy_pos_q <= 1'b1;
      p1_scored_q  <= 1'b0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
`ifdef PONG_BALL_SPEEDUP_EN
      speed_q      <= 3'd1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      srv_cnt_q    <= srv_cnt_d;
      x_ball_q     <= x_ball_d;
      y_ball_q     <= y_ball_d;
      dx_pos_q     <= dx_pos_d;
      dy_pos_q     <= dy_pos_d;
      srv_dy_pos_q <= srv_dy_pos_d;
      p1_scored_q  <= p1_scored_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
`ifdef PONG_BALL_SPEEDUP_EN
      speed_q      <= speed_d;
`endif
    end
  end

  // Output decode: pixel hit test and status flags.
  always_comb begin
    ball_on   = (state_q != S_OVER)
                && (xs >= sx - HALF_S) && (xs < sx + HALF_S)
                && (ys >= sy - HALF_S) && (ys < sy + HALF_S);
    rgb_ball  = 12'hFFF;
    x_ball    = x_ball_q;
    y_ball    = y_ball_q;
    score1    = score1_q;
    score2    = score2_q;
    point1    = (state_q == S_POINT) && p1_scored_q;
    point2    = (state_q == S_POINT) && !p1_scored_q;
    game_over = (state_q == S_OVER);
  end

endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball: directed bench for pong_ball with TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=2.
module tb_pong_ball;

  logic        clk, reset;
  logic [9:0]  x, y, x_paddle1, y_paddle1, x_paddle2, y_paddle2;
  logic        ball_on, point1, point2, game_over;
  logic [11:0] rgb_ball;
  logic [9:0]  x_ball, y_ball;
  logic [3:0]  score1, score2;

  pong_ball #(.TICK_DIV(4), .SERVE_TICKS(2), .WIN_SCORE(2)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .x_paddle1(x_paddle1), .y_paddle1(y_paddle1),
    .x_paddle2(x_paddle2), .y_paddle2(y_paddle2),
    .ball_on(ball_on), .rgb_ball(rgb_ball), .x_ball(x_ball), .y_ball(y_ball),
    .score1(score1), .score2(score2), .point1(point1), .point2(point2),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edges  = 0;   // posedges since the last reset release
  int pulses = 0;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       on;
  } pix_t;

  // Ball position after move n of the first rally (move n lands on posedge 4*(n+2)).
  typedef struct {
    int n;
    int xb;
    int yb;
  } traj_t;

  always @(negedge clk) if (reset && (point1 || point2)) pulses++;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
    edges += k;
  endtask

  task automatic wait_point(output int who);
    who = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (point1) begin who = 1; break; end
      if (point2) begin who = 2; break; end
    end
  endtask

  pix_t  pix[7];
  traj_t traj[10];
  int    who;

  initial begin
    pix[0] = '{10'd316, 10'd236, 1'b1};
    pix[1] = '{10'd323, 10'd243, 1'b1};
    pix[2] = '{10'd320, 10'd240, 1'b1};
    pix[3] = '{10'd315, 10'd240, 1'b0};
    pix[4] = '{10'd324, 10'd240, 1'b0};
    pix[5] = '{10'd320, 10'd235, 1'b0};
    pix[6] = '{10'd320, 10'd244, 1'b0};

    traj[0] = '{1,   321, 241};   // first move after serve
    traj[1] = '{236, 556, 476};   // bottom wall
    traj[2] = '{237, 557, 475};
    traj[3] = '{279, 599, 433};
    traj[4] = '{280, 600, 432};   // paddle2 hit snaps to 612-8-4
    traj[5] = '{281, 599, 431};
    traj[6] = '{707, 173, 5};
    traj[7] = '{708, 172, 4};     // top wall
    traj[8] = '{709, 171, 5};
    traj[9] = '{875, 5,   171};

    x = 10'd0; y = 10'd0;
    x_paddle1 = 10'd20;  y_paddle1 = 10'd40;
    x_paddle2 = 10'd612; y_paddle2 = 10'd420;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_x_ball", x_ball, 320);
    check("rst_y_ball", y_ball, 240);
    check("rst_score1", score1, 0);
    check("rst_score2", score2, 0);
    check("rst_game_over", game_over, 0);
    check("rst_point", {point1, point2}, 0);
    check("rgb_ball", rgb_ball, 12'hFFF);
    for (int i = 0; i < 7; i++) begin
      x = pix[i].px; y = pix[i].py;
      #1 check($sformatf("ball_on[%0d]", i), ball_on, pix[i].on);
    end

    // Game 1: serve hold, long rally with wall and paddle2 bounces, P1 miss.
    @(negedge clk);
    reset = 1'b1;
    edges = 0;
    step(7);
    check("serve_hold_x", x_ball, 320);
    step(1);
    check("serve_hold2_y", y_ball, 240);
    for (int i = 0; i < 10; i++) begin
      step(4 * (traj[i].n + 2) - edges);
      check($sformatf("traj_x[n=%0d]", traj[i].n), x_ball, traj[i].xb);
      check($sformatf("traj_y[n=%0d]", traj[i].n), y_ball, traj[i].yb);
    end
    check("no_pulse_on_hits", pulses, 0);
    step(4 * 878 - edges);
    check("miss_point2", point2, 1);
    check("miss_point1", point1, 0);
    check("miss_score2", score2, 1);
    check("miss_score1", score1, 0);
    step(1);
    check("point_one_clk", point2, 0);
    check("recentre_x", x_ball, 320);
    check("recentre_y", y_ball, 240);
    step(4 * 880 + 3 - edges);
    check("serve2_hold_x", x_ball, 320);
    step(1);
    check("serve2_x", x_ball, 319);   // toward P1, who conceded
    check("serve2_y", y_ball, 239);   // dy toggled to up
    check("pulse_count", pulses, 1);

    // Asynchronous reset mid-play, away from any clock edge.
    #2 reset = 1'b0;
    #1;
    check("async_rst_x", x_ball, 320);
    check("async_rst_y", y_ball, 240);
    check("async_rst_score2", score2, 0);
    check("async_rst_over", game_over, 0);

    // Game 2: paddle2 high, P2 misses once, then P1 misses twice.
    y_paddle2 = 10'd40;
    x = 10'd320; y = 10'd240;
    @(negedge clk);
    reset = 1'b1;
    wait_point(who);
    check("g2_first_point", who, 1);
    check("g2_score1", score1, 1);
    step(1);
    check("g2_recentre_x", x_ball, 320);
    check("g2_over_early", game_over, 0);
    wait_point(who);
    check("g2_second_point", who, 2);
    check("g2_score2a", score2, 1);
    step(1);
    check("g2_not_over", game_over, 0);
    wait_point(who);
    check("g2_third_point", who, 2);
    check("g2_score2b", score2, 2);
    step(1);
    check("over_flag", game_over, 1);
    check("over_ball_on", ball_on, 0);
    check("over_x", x_ball, 320);
    step(40);
    check("over_hold_x", x_ball, 320);
    check("over_hold_y", y_ball, 240);
    check("over_hold_s1", score1, 1);
    check("over_hold_s2", score2, 2);
    check("over_hold_flag", game_over, 1);

    reset = 1'b0;
    #1;
    check("final_rst_over", game_over, 0);
    check("final_rst_ball_on", ball_on, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
